// File: rtl/bsg_fsb_node_power_seq.sv
// Power/isolation sequencer for one FSB node in a switchable power domain.
// Orders switch enable, level-shifter enable, node reset and the FSB traffic gate.
module bsg_fsb_node_power_seq #(
  parameter int pwr_good_timeout_p = 255,
  parameter int reset_cycles_p     = 16,
  parameter int drain_idle_p       = 8,
  parameter int drain_timeout_p    = 1023
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       on_req_i,
  input  logic       off_req_i,
  input  logic       pwr_good_i,
  input  logic       fsb_v_o_i,
  input  logic       node_v_o_i,
  output logic       pwr_en_o,
  output logic       en_ls_o,
  output logic       node_reset_o,
  output logic       gate_o,
  output logic       on_o,
  output logic       err_o,
  output logic [2:0] state_o
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_P = max_of(max_of(pwr_good_timeout_p, reset_cycles_p),
                                max_of(drain_idle_p, drain_timeout_p));
  localparam int CNT_W = (MAX_P < 2) ? 1 : $clog2(MAX_P + 1);

  localparam logic [CNT_W:0] PG_TO    = (CNT_W+1)'(pwr_good_timeout_p);
  localparam logic [CNT_W:0] RST_CYC  = (CNT_W+1)'(reset_cycles_p);
  localparam logic [CNT_W:0] IDLE_CYC = (CNT_W+1)'(drain_idle_p);
  localparam logic [CNT_W:0] DRAIN_TO = (CNT_W+1)'(drain_timeout_p);

  localparam logic [2:0] ST_OFF      = 3'd0;
  localparam logic [2:0] ST_PWR_UP   = 3'd1;
  localparam logic [2:0] ST_NODE_RST = 3'd2;
  localparam logic [2:0] ST_ON       = 3'd3;
  localparam logic [2:0] ST_DRAIN    = 3'd4;
  localparam logic [2:0] ST_ISO      = 3'd5;
  localparam logic [2:0] ST_PWR_DN   = 3'd6;

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_idle_cnt;
  logic             r_err;
  logic             w_set_err;
  logic             w_clr_err;
  logic             w_idle;
  logic [CNT_W:0]   w_cnt_inc;
  logic [CNT_W:0]   w_idle_inc;

  // Increments are one wider so "this cycle completes N" never overflows.
  assign w_idle     = ~fsb_v_o_i & ~node_v_o_i;
  assign w_cnt_inc  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_idle_inc = {1'b0, r_idle_cnt} + {{CNT_W{1'b0}}, 1'b1};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= ST_OFF;
      r_cnt      <= '0;
      r_idle_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state)
        r_cnt <= '0;
      else if (r_cnt != {CNT_W{1'b1}})
        r_cnt <= r_cnt + 1'b1;
      if ((w_next_state != r_state) || !w_idle)
        r_idle_cnt <= '0;
      else if (r_idle_cnt != {CNT_W{1'b1}})
        r_idle_cnt <= r_idle_cnt + 1'b1;
      if (w_set_err)
        r_err <= 1'b1;
      else if (w_clr_err)
        r_err <= 1'b0;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_set_err    = 1'b0;
    w_clr_err    = 1'b0;
    case (r_state)
      ST_PWR_UP: begin
        if (pwr_good_i) begin
          w_next_state = ST_NODE_RST;
        end else if (w_cnt_inc >= PG_TO) begin
          w_next_state = ST_PWR_DN;
          w_set_err    = 1'b1;
        end
      end
      ST_NODE_RST: begin
        if (!pwr_good_i) begin
          w_next_state = ST_ISO;
          w_set_err    = 1'b1;
        end else if (w_cnt_inc >= RST_CYC) begin
          w_next_state = ST_ON;
        end
      end
      ST_ON: begin
        if (!pwr_good_i) begin
          w_next_state = ST_ISO;
          w_set_err    = 1'b1;
        end else if (off_req_i) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Power loss, then timeout, then a completed idle run, then abort.
        if (!pwr_good_i) begin
          w_next_state = ST_ISO;
          w_set_err    = 1'b1;
        end else if (w_cnt_inc >= DRAIN_TO) begin
          w_next_state = ST_ISO;
          w_set_err    = 1'b1;
        end else if (w_idle && (w_idle_inc >= IDLE_CYC)) begin
          w_next_state = ST_ISO;
        end else if (on_req_i && !off_req_i) begin
          w_next_state = ST_ON;
        end
      end
      ST_ISO: begin
        w_next_state = ST_PWR_DN;
      end
      ST_PWR_DN: begin
        if (!pwr_good_i) begin
          w_next_state = ST_OFF;
        end else if (w_cnt_inc >= PG_TO) begin
          w_next_state = ST_OFF;
          w_set_err    = 1'b1;
        end
      end
      default: begin
        // OFF, and the unused encoding 7 behaves the same way.
        if (on_req_i) begin
          w_next_state = ST_PWR_UP;
          w_clr_err    = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    pwr_en_o     = 1'b0;
    en_ls_o      = 1'b0;
    node_reset_o = 1'b1;
    gate_o       = 1'b1;
    on_o         = 1'b0;
    case (r_state)
      ST_PWR_UP: begin
        pwr_en_o = 1'b1;
      end
      ST_NODE_RST: begin
        pwr_en_o = 1'b1;
        en_ls_o  = 1'b1;
      end
      ST_ON: begin
        pwr_en_o     = 1'b1;
        en_ls_o      = 1'b1;
        node_reset_o = 1'b0;
        gate_o       = 1'b0;
        on_o         = 1'b1;
      end
      ST_DRAIN: begin
        pwr_en_o     = 1'b1;
        en_ls_o      = 1'b1;
        node_reset_o = 1'b0;
      end
      ST_ISO: begin
        pwr_en_o = 1'b1;
      end
      default: begin
        pwr_en_o = 1'b0;
      end
    endcase
  end

  assign err_o   = r_err;
  assign state_o = r_state;

endmodule

// File: tb/tb_bsg_fsb_node_power_seq.sv
// Bench for bsg_fsb_node_power_seq: directed sequences with literal timing
// expectations plus random traffic checked every cycle against a reference model.
module tb_bsg_fsb_node_power_seq;

  localparam int PG_TO    = 255;
  localparam int RST_CYC  = 16;
  localparam int IDLE_CYC = 8;
  localparam int DRAIN_TO = 1023;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       on_req_i = 1'b0;
  logic       off_req_i = 1'b0;
  logic       pwr_good_i = 1'b0;
  logic       fsb_v_o_i = 1'b0;
  logic       node_v_o_i = 1'b0;
  logic       pwr_en_o, en_ls_o, node_reset_o, gate_o, on_o, err_o;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_errors = 0;

  bsg_fsb_node_power_seq #(
    .pwr_good_timeout_p(PG_TO),
    .reset_cycles_p    (RST_CYC),
    .drain_idle_p      (IDLE_CYC),
    .drain_timeout_p   (DRAIN_TO)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .on_req_i    (on_req_i),
    .off_req_i   (off_req_i),
    .pwr_good_i  (pwr_good_i),
    .fsb_v_o_i   (fsb_v_o_i),
    .node_v_o_i  (node_v_o_i),
    .pwr_en_o    (pwr_en_o),
    .en_ls_o     (en_ls_o),
    .node_reset_o(node_reset_o),
    .gate_o      (gate_o),
    .on_o        (on_o),
    .err_o       (err_o),
    .state_o     (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Output table per state: {pwr_en, en_ls, node_reset, gate}.
  logic [3:0] dec_tab [0:7] = '{4'b0011, 4'b1011, 4'b1111, 4'b1100,
                                4'b1101, 4'b1011, 4'b0011, 4'b0011};
  logic [8:0] exp_q[$];
  int  m_st = 0;
  int  m_time = 0;
  int  m_idle = 0;
  bit  m_err = 1'b0;
  int  m_nx;
  bit  m_quiet;

  function automatic logic [8:0] model_vec(input int st, input bit err);
    logic [2:0] s3;
    s3 = 3'(st);
    return {s3, dec_tab[s3], (st == 3), err};
  endfunction

  always @(posedge clk) begin
    if (reset_i) begin
      m_st = 0; m_time = 0; m_idle = 0; m_err = 1'b0;
    end else begin
      m_nx    = m_st;
      m_quiet = !fsb_v_o_i && !node_v_o_i;
      case (m_st)
        1: if (pwr_good_i) m_nx = 2;
           else if (m_time + 1 >= PG_TO) begin m_nx = 6; m_err = 1'b1; end
        2: if (!pwr_good_i) begin m_nx = 5; m_err = 1'b1; end
           else if (m_time + 1 >= RST_CYC) m_nx = 3;
        3: if (!pwr_good_i) begin m_nx = 5; m_err = 1'b1; end
           else if (off_req_i) m_nx = 4;
        4: if (!pwr_good_i) begin m_nx = 5; m_err = 1'b1; end
           else if (m_time + 1 >= DRAIN_TO) begin m_nx = 5; m_err = 1'b1; end
           else if (m_quiet && (m_idle + 1 >= IDLE_CYC)) m_nx = 5;
           else if (on_req_i && !off_req_i) m_nx = 3;
        5: m_nx = 6;
        6: if (!pwr_good_i) m_nx = 0;
           else if (m_time + 1 >= PG_TO) begin m_nx = 0; m_err = 1'b1; end
        default: if (on_req_i) begin m_nx = 1; m_err = 1'b0; end
      endcase
      m_idle = (m_nx == m_st && m_quiet) ? m_idle + 1 : 0;
      m_time = (m_nx == m_st) ? m_time + 1 : 0;
      m_st   = m_nx;
    end
    exp_q.push_back(model_vec(m_st, m_err));
  end

  // scoreboard compare, away from the active edge
  logic [8:0] dut_vec;
  logic [8:0] exp_vec;
  assign dut_vec = {state_o, pwr_en_o, en_ls_o, node_reset_o, gate_o, on_o, err_o};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_vec = exp_q.pop_front();
      check("cycle_vec", int'(dut_vec), int'(exp_vec));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string nm);
    int k;
    k = 0;
    while (state_o !== st && k < budget) begin
      step();
      k++;
    end
    if (state_o !== st) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: timed out waiting for state %0d, got %0d", nm, st, state_o);
    end
  endtask

  task automatic power_up();
    on_req_i   = 1'b1;
    pwr_good_i = 1'b1;
    step();
    on_req_i = 1'b0;
    wait_state(3'd3, 100, "power_up");
  endtask

  int s  [0:40];
  int ls [0:40];
  int nr [0:40];
  int pe [0:40];
  int er [0:40];
  int cnt;
  int rst_vec;

  initial begin
    rst_vec = int'(9'b000_0011_00);

    // reset
    reset_i = 1'b1;
    repeat (3) step();
    check("reset_vec", int'(dut_vec), rst_vec);
    reset_i = 1'b0;
    step();

    // power-up timing: pwr_good rises in cycle 3
    on_req_i = 1'b1;
    for (int t = 1; t <= 22; t++) begin
      step();
      if (t == 1) on_req_i = 1'b0;
      if (t == 3) pwr_good_i = 1'b1;
      s[t] = int'(state_o); ls[t] = int'(en_ls_o); nr[t] = int'(node_reset_o);
    end
    check("up_t1_pwr_up", s[1], 1);
    check("up_t3_pwr_up", s[3], 1);
    check("up_t4_node_rst", s[4], 2);
    check("up_t19_node_rst", s[19], 2);
    check("up_t20_on", s[20], 3);
    check("up_t3_en_ls", ls[3], 0);
    check("up_t4_en_ls", ls[4], 1);
    check("up_t19_node_reset", nr[19], 1);
    check("up_t20_node_reset", nr[20], 0);

    // clean power-down with idle valids, pwr_good falls in cycle 12
    off_req_i = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      step();
      if (t == 1) off_req_i = 1'b0;
      if (t == 12) pwr_good_i = 1'b0;
      s[t] = int'(state_o); pe[t] = int'(pwr_en_o); er[t] = int'(err_o);
    end
    check("dn_t1_drain", s[1], 4);
    check("dn_t8_drain", s[8], 4);
    check("dn_t9_iso", s[9], 5);
    check("dn_t10_pwr_dn", s[10], 6);
    check("dn_t9_pwr_en", pe[9], 1);
    check("dn_t10_pwr_en", pe[10], 0);
    check("dn_t12_pwr_dn", s[12], 6);
    check("dn_t13_off", s[13], 0);
    check("dn_t13_err", er[13], 0);

    // busy drain: idle runs never reach the idle threshold
    power_up();
    off_req_i = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 1100; k++) begin
      step();
      off_req_i = 1'b0;
      fsb_v_o_i = 1'((k / 4) % 2);
      if (state_o == 3'd4) cnt++;
      else break;
    end
    check("busy_drain_cycles", cnt, DRAIN_TO);
    check("busy_drain_iso", int'(state_o), 5);
    check("busy_drain_err", int'(err_o), 1);
    fsb_v_o_i  = 1'b0;
    pwr_good_i = 1'b0;
    wait_state(3'd0, 10, "busy_drain_off");

    // no power-good: PWR_UP times out
    on_req_i = 1'b1;
    step();
    on_req_i = 1'b0;
    check("nopg_err_cleared", int'(err_o), 0);
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      if (state_o == 3'd1) cnt++;
      else break;
      step();
    end
    check("nopg_pwr_up_cycles", cnt, PG_TO);
    check("nopg_pwr_dn", int'(state_o), 6);
    step();
    check("nopg_off", int'(state_o), 0);
    check("nopg_err", int'(err_o), 1);
    on_req_i = 1'b1;
    step();
    on_req_i = 1'b0;
    check("nopg_err_cleared_again", int'(err_o), 0);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("reset_vec_2", int'(dut_vec), rst_vec);

    // brown-out in ON
    power_up();
    pwr_good_i = 1'b0;
    step();
    check("brown_iso", int'(state_o), 5);
    check("brown_en_ls", int'(en_ls_o), 0);
    check("brown_node_reset", int'(node_reset_o), 1);
    check("brown_err", int'(err_o), 1);
    step();
    check("brown_pwr_dn", int'(state_o), 6);
    step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;

    // reset in NODE_RST
    on_req_i   = 1'b1;
    pwr_good_i = 1'b1;
    step();
    on_req_i = 1'b0;
    step();
    check("rst_in_node_rst_pre", int'(state_o), 2);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("rst_in_node_rst", int'(dut_vec), rst_vec);

    // on_req+off_req together in ON, then reset in DRAIN
    power_up();
    on_req_i  = 1'b1;
    off_req_i = 1'b1;
    step();
    on_req_i  = 1'b0;
    off_req_i = 1'b0;
    check("both_req_drain", int'(state_o), 4);
    fsb_v_o_i = 1'b1;
    step();
    reset_i = 1'b1;
    step();
    reset_i   = 1'b0;
    fsb_v_o_i = 1'b0;
    check("rst_in_drain", int'(dut_vec), rst_vec);

    // random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      step();
      reset_i    = ($urandom_range(0, 999) == 0);
      on_req_i   = ($urandom_range(0, 19) == 0);
      off_req_i  = ($urandom_range(0, 29) == 0);
      fsb_v_o_i  = ($urandom_range(0, 3) == 0);
      node_v_o_i = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 99)) inside
        [0:29]:  pwr_good_i = pwr_en_o;
        99:      pwr_good_i = ~pwr_good_i;
        default: pwr_good_i = pwr_good_i;
      endcase
    end
    reset_i = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
